guess_turn_scheduler: RTL and testbench
=======================================

// Module: guess_turn_scheduler
// PURPOSE
//  Two-player turn scheduler in front of the word-guess game core. Takes one keypad letter at a time from the
//  player whose turn it is, filters bad or repeated letters, and issues each accepted letter to the core as a
//  one-cycle guess pulse. Watches the core's game_rdy/red_busy/mistake handshake and passes the turn on a miss
//  or a turn timeout. Sits between the two keypad decoders and the game core's guess input.
// PARAMETERS
//  TURN_CYCLES  50_000_000  cycles the active player may idle before the turn passes (>=2)
//  TIMER_W      26          turn-timer width; must satisfy 2**TIMER_W > TURN_CYCLES
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  p1_key        in   8   player 1 ASCII letter; qualified by p1_valid
//  p1_valid      in   1   player 1 key present; held until p1_ack
//  p2_key        in   8   player 2 ASCII letter
//  p2_valid      in   1   player 2 key present; held until p2_ack
//  game_rdy      in   1   core ready for a guess (core FIRST/STOP/IDLE states)
//  red_busy      in   1   core is comparing letters (core L0..L4 states)
//  mistake       in   1   core miss flag; valid in the cycle red_busy falls
//  correct       in   3   core correct-letter count
//  incorrect     in   3   core mistake count
//  game_end      in   1   new-game request; the core also returns to SET
//  guess         out  8   letter to the core; nonzero for exactly one cycle per issue, 0 otherwise
//  p1_ack        out  1   one-cycle pulse: player 1 key consumed (accepted or rejected)
//  p2_ack        out  1   one-cycle pulse: player 2 key consumed
//  active_player out  1   0 = player 1, 1 = player 2
//  dup_reject    out  1   one-cycle pulse: key was non A-Z or already used
//  turn_timeout  out  1   one-cycle pulse: turn passed by timeout
//  proto_err     out  1   one-cycle pulse: core did not raise red_busy after an issue
//  game_over     out  1   level: correct==5 or incorrect==6
//  used_mask     out  26  bit i set when letter 'A'+i has been issued
// BEHAVIOUR
//  Reset value of every output is 0; state goes to S_WAIT and the timer clears. game_over is combinational from
//  correct/incorrect; the other outputs are registered.
//  Only 8'h41..8'h5A are legal letters; idx = key - 8'h41.
//  S_WAIT:
//   - The active player's key is taken when game_rdy=1, the active player's valid=1 and game_over=0.
//   - If the key is illegal or used_mask[idx]=1: ack and dup_reject pulse in the same cycle. Stay in S_WAIT.
//     The timer is not reset.
//   - Otherwise: ack pulses, guess<=key on the next cycle, used_mask[idx]<=1, go to S_ISSUE.
//   - The inactive player's valid is never acked and has no other effect.
//  S_ISSUE (1 cycle): guess is nonzero here only. Go to S_BUSY with a 2-cycle watchdog.
//  S_BUSY: wait for red_busy=1, then go to S_RESULT. If red_busy stays 0 for 2 cycles: proto_err pulses,
//   go to S_WAIT, no turn change.
//  S_RESULT: wait for red_busy=0; sample mistake in that cycle.
//   - mistake=1: active_player toggles.
//   - mistake=0: the same player keeps the turn.
//   Then go to S_WAIT and clear the timer.
//  Turn timer: counts only in S_WAIT with game_rdy=1 and game_over=0. At TURN_CYCLES-1: active_player toggles,
//   turn_timeout pulses, timer clears. A legal key taken in the same cycle wins; no timeout fires.
//  Game over: while game_over=1, no keys are taken and the timer is frozen. Issues already in flight complete.
//  game_end (any state): used_mask<=0, active_player<=0, timer<=0, guess<=0, state<=S_WAIT. No ack or pulses
//   that cycle. game_end takes priority over every other event, including rst-free mid-issue.
//  Keys arriving while in S_ISSUE/S_BUSY/S_RESULT wait, held, until S_WAIT.
// TESTING
//  T1 rst, game_rdy=1, p1 'C': p1_ack, then guess=8'h43 one cycle, red_busy 5 cycles, mistake=0 -> player stays 0,
//     used_mask[2]=1
//  T2 same as T1 with mistake=1 when red_busy falls -> active_player=1; p1_valid thereafter is never acked
//  T3 p1 'C' again after T1 -> p1_ack+dup_reject same cycle, guess stays 0; key 8'h61 ('a') -> dup_reject
//  T4 TURN_CYCLES=16, no keys -> turn_timeout at the 16th counting cycle, player toggles; key on cycle 16 wins
//  T5 correct=5 -> game_over=1, valid keys not acked; game_end -> used_mask=0, player=0, keys accepted again
//  T6 issue with red_busy held 0 -> proto_err 2 cycles after S_ISSUE, back to S_WAIT, same player

Source files
------------

// File: rtl/guess_turn_if.sv
// Handshake bundle between the keypad decoders, the game core and the turn scheduler.
// The scheduler takes the slave side; whatever drives keys and core status takes master.
interface guess_turn_if;
  logic [7:0]  p1_key;
  logic        p1_valid;
  logic [7:0]  p2_key;
  logic        p2_valid;
  logic        game_rdy;
  logic        red_busy;
  logic        mistake;
  logic [2:0]  correct;
  logic [2:0]  incorrect;
  logic        game_end;
  logic [7:0]  guess;
  logic        p1_ack;
  logic        p2_ack;
  logic        active_player;
  logic        dup_reject;
  logic        turn_timeout;
  logic        proto_err;
  logic        game_over;
  logic [25:0] used_mask;

  modport master (
    output p1_key, p1_valid, p2_key, p2_valid, game_rdy, red_busy, mistake,
           correct, incorrect, game_end,
    input  guess, p1_ack, p2_ack, active_player, dup_reject, turn_timeout,
           proto_err, game_over, used_mask
  );

  modport slave (
    input  p1_key, p1_valid, p2_key, p2_valid, game_rdy, red_busy, mistake,
           correct, incorrect, game_end,
    output guess, p1_ack, p2_ack, active_player, dup_reject, turn_timeout,
           proto_err, game_over, used_mask
  );
endinterface

// File: rtl/guess_turn_scheduler.sv
// Two-player turn scheduler: filters keypad letters, issues one-cycle guesses to the core,
// and hands the turn over on a miss or when the active player idles too long.
//
// state    | meaning
// S_WAIT   | waiting for the active player's key; turn timer runs here
// S_ISSUE  | accepted letter is driven on guess for one cycle
// S_BUSY   | waiting for the core to raise red_busy (2-cycle watchdog)
// S_RESULT | core comparing; mistake sampled as red_busy falls
module guess_turn_scheduler #(
  parameter int unsigned TURN_CYCLES = 50_000_000,
  parameter int unsigned TIMER_W     = 26
) (
  input logic        clk,
  input logic        rst,
  guess_turn_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUSY   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 wd_q, wd_d;
  logic [25:0]          used_q, used_d;
  logic                 active_q, active_d;
  logic [7:0]           key_q, key_d;
  logic [7:0]           guess_q, guess_d;
  logic                 ack1_q, ack1_d;
  logic                 ack2_q, ack2_d;
  logic                 dup_q, dup_d;
  logic                 timeout_q, timeout_d;
  logic                 perr_q, perr_d;

  logic                 game_over;
  logic                 act_valid;
  logic [7:0]           act_key;
  logic                 legal;
  logic [4:0]           idx;
  logic                 take;
  logic                 accept;
  logic                 count_en;
  logic                 timer_tc;

  assign game_over = (bus.correct == 3'd5) || (bus.incorrect == 3'd6);

  assign act_valid = active_q ? bus.p2_valid : bus.p1_valid;
  assign act_key   = active_q ? bus.p2_key   : bus.p1_key;
  assign legal     = (act_key >= 8'h41) && (act_key <= 8'h5A);
  assign idx       = 5'(act_key - 8'h41);

  // idx is only meaningful for legal keys, so the used-bit lookup is gated by legal
  assign take     = (state_q == S_WAIT) && bus.game_rdy && act_valid && !game_over;
  assign accept   = take && legal && !used_q[idx];
  assign count_en = (state_q == S_WAIT) && bus.game_rdy && !game_over;
  assign timer_tc = (timer_q == TIMER_W'(TURN_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wd_d      = wd_q;
    used_d    = used_q;
    active_d  = active_q;
    key_d     = key_q;
    guess_d   = 8'h00;
    ack1_d    = 1'b0;
    ack2_d    = 1'b0;
    dup_d     = 1'b0;
    timeout_d = 1'b0;
    perr_d    = 1'b0;

    if (bus.game_end) begin
      state_d  = S_WAIT;
      timer_d  = '0;
      wd_d     = 1'b0;
      used_d   = '0;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          // an accepted key outranks a timeout landing in the same cycle
          if (count_en) begin
            if (accept) begin
              timer_d = '0;
            end else if (timer_tc) begin
              timer_d   = '0;
              active_d  = ~active_q;
              timeout_d = 1'b1;
            end else begin
              timer_d = timer_q + TIMER_W'(1);
            end
          end
          if (take) begin
            ack1_d = ~active_q;
            ack2_d = active_q;
            if (accept) begin
              key_d       = act_key;
              used_d[idx] = 1'b1;
              state_d     = S_ISSUE;
            end else begin
              dup_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          guess_d = key_q;
          wd_d    = 1'b0;
          state_d = S_BUSY;
        end
        S_BUSY: begin
          if (bus.red_busy) begin
            state_d = S_RESULT;
          end else if (wd_q) begin
            perr_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            wd_d = 1'b1;
          end
        end
        S_RESULT: begin
          if (!bus.red_busy) begin
            if (bus.mistake) begin
              active_d = ~active_q;
            end
            timer_d = '0;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT;
      timer_q   <= '0;
      wd_q      <= 1'b0;
      used_q    <= '0;
      active_q  <= 1'b0;
      key_q     <= 8'h00;
      guess_q   <= 8'h00;
      ack1_q    <= 1'b0;
      ack2_q    <= 1'b0;
      dup_q     <= 1'b0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wd_q      <= wd_d;
      used_q    <= used_d;
      active_q  <= active_d;
      key_q     <= key_d;
      guess_q   <= guess_d;
      ack1_q    <= ack1_d;
      ack2_q    <= ack2_d;
      dup_q     <= dup_d;
      timeout_q <= timeout_d;
      perr_q    <= perr_d;
    end
  end

  assign bus.guess         = guess_q;
  assign bus.p1_ack        = ack1_q;
  assign bus.p2_ack        = ack2_q;
  assign bus.active_player = active_q;
  assign bus.dup_reject    = dup_q;
  assign bus.turn_timeout  = timeout_q;
  assign bus.proto_err     = perr_q;
  assign bus.game_over     = game_over;
  assign bus.used_mask     = used_q;

endmodule

// File: tb/tb_guess_turn_scheduler.sv
// Bench for guess_turn_scheduler: directed key table, timer/game-over/game_end sequences,
// then random keys checked against a letter-set/turn model.
module tb_guess_turn_scheduler;

  logic clk = 1'b0;
  logic rst;
  guess_turn_if bus ();

  guess_turn_scheduler #(.TURN_CYCLES(16), .TIMER_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit mdl_used [26];
  bit mdl_player;

  typedef struct {
    logic [7:0] key;
    bit         rej;
    int         bdelay;   // 0/1 cycles until red_busy, 2 = never
    bit         mis;
    int         hold;
    bit         other;    // also wave the inactive player's key
    bit         pl;       // expected active player afterwards
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] mask_vec();
    logic [25:0] m;
    for (int i = 0; i < 26; i++) m[i] = mdl_used[i];
    return m;
  endfunction

  function automatic bit is_letter(input logic [7:0] k);
    return (k >= 8'h41) && (k <= 8'h5A);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 26; i++) mdl_used[i] = 1'b0;
    mdl_player = 1'b0;
  endtask

  task automatic drop_keys();
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    bus.game_rdy = 1'b0;
  endtask

  // Called and returns at a negedge with the DUT waiting for a key.
  task automatic do_key(input logic [7:0] key, input bit exp_rej, input int bdelay,
                        input bit mis, input int hold, input bit other, input bit exp_pl);
    logic [7:0] okey;
    okey = 8'(8'h41 + $urandom_range(0, 25));
    chk("player_before", bus.active_player, mdl_player);
    bus.game_rdy = 1'b1;
    if (!mdl_player) begin
      bus.p1_key = key;  bus.p1_valid = 1'b1;
      bus.p2_key = okey; bus.p2_valid = other;
    end else begin
      bus.p2_key = key;  bus.p2_valid = 1'b1;
      bus.p1_key = okey; bus.p1_valid = other;
    end
    @(negedge clk);
    chk("ack_active", mdl_player ? bus.p2_ack : bus.p1_ack, 1);
    chk("ack_inactive", mdl_player ? bus.p1_ack : bus.p2_ack, 0);
    chk("dup_reject", bus.dup_reject, exp_rej);
    chk("timeout_quiet", bus.turn_timeout, 0);
    chk("guess_in_ack_cycle", bus.guess, 0);
    drop_keys();
    if (!exp_rej) begin
      mdl_used[int'(key) - 65] = 1'b1;
      @(negedge clk);
      chk("guess_issue", bus.guess, key);
      chk("ack_after_issue", {bus.p1_ack, bus.p2_ack}, 0);
      if (bdelay == 0) bus.red_busy = 1'b1;
      @(negedge clk);
      chk("guess_one_cycle", bus.guess, 0);
      chk("proto_quiet", bus.proto_err, 0);
      if (bdelay == 1) bus.red_busy = 1'b1;
      if (bdelay >= 2) begin
        @(negedge clk);
        chk("proto_err", bus.proto_err, 1);
        @(negedge clk);
        chk("proto_err_pulse", bus.proto_err, 0);
      end else begin
        repeat (hold) @(negedge clk);
        bus.red_busy = 1'b0;
        bus.mistake  = mis;
        @(negedge clk);
        bus.mistake = 1'b0;
        chk("proto_quiet_result", bus.proto_err, 0);
      end
    end
    chk("player_after", bus.active_player, exp_pl);
    chk("used_mask", bus.used_mask, mask_vec());
    mdl_player = exp_pl;
  endtask

  task automatic pulse_game_end();
    bus.game_end = 1'b1;
    drop_keys();
    @(negedge clk);
    bus.game_end = 1'b0;
    clear_model();
    chk("ge_used_mask", bus.used_mask, 0);
    chk("ge_player", bus.active_player, 0);
    chk("ge_no_ack", {bus.p1_ack, bus.p2_ack, bus.dup_reject}, 0);
  endtask

  initial begin
    logic [7:0] k;
    bit         rej;
    bit         npl;
    int         streak;
    int         r;
    int         bd;
    bit         mis;

    tbl[0] = '{8'h43, 1'b0, 0, 1'b0, 5, 1'b0, 1'b0};
    tbl[1] = '{8'h43, 1'b1, 0, 1'b0, 1, 1'b0, 1'b0};
    tbl[2] = '{8'h61, 1'b1, 0, 1'b0, 1, 1'b1, 1'b0};
    tbl[3] = '{8'h41, 1'b0, 0, 1'b1, 2, 1'b0, 1'b1};
    tbl[4] = '{8'h5A, 1'b0, 1, 1'b0, 3, 1'b1, 1'b1};
    tbl[5] = '{8'h40, 1'b1, 0, 1'b0, 1, 1'b1, 1'b1};
    tbl[6] = '{8'h5B, 1'b1, 0, 1'b0, 1, 1'b0, 1'b1};
    tbl[7] = '{8'h4D, 1'b0, 2, 1'b0, 1, 1'b0, 1'b1};
    tbl[8] = '{8'h4D, 1'b1, 0, 1'b0, 1, 1'b1, 1'b1};
    tbl[9] = '{8'h42, 1'b0, 0, 1'b1, 1, 1'b1, 1'b0};

    rst = 1'b1;
    bus.p1_key = 8'h00; bus.p2_key = 8'h00;
    drop_keys();
    bus.red_busy = 1'b0; bus.mistake = 1'b0;
    bus.correct = 3'd0;  bus.incorrect = 3'd0;
    bus.game_end = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bus.guess, bus.p1_ack, bus.p2_ack, bus.active_player, bus.dup_reject,
                        bus.turn_timeout, bus.proto_err, bus.game_over}, 0);
    chk("rst_used_mask", bus.used_mask, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      do_key(tbl[i].key, tbl[i].rej, tbl[i].bdelay, tbl[i].mis, tbl[i].hold, tbl[i].other, tbl[i].pl);

    // game_end right after an accept: issue is cancelled, nothing reaches the core
    bus.game_rdy = 1'b1; bus.p1_key = 8'h51; bus.p1_valid = 1'b1;
    @(negedge clk);
    chk("ge_mid_ack", bus.p1_ack, 1);
    pulse_game_end();
    chk("ge_mid_guess", bus.guess, 0);
    @(negedge clk);
    chk("ge_mid_guess_later", bus.guess, 0);

    // turn timeout after 16 idle counting cycles, then a key on the 16th cycle beats it
    bus.game_rdy = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("timeout_early", bus.turn_timeout, 0);
    end
    @(negedge clk);
    chk("timeout_fires", bus.turn_timeout, 1);
    chk("timeout_player", bus.active_player, 1);
    mdl_player = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("timeout_second_early", bus.turn_timeout, 0);
    end
    do_key(8'h51, 1'b0, 0, 1'b0, 2, 1'b0, 1'b1);

    // game over blocks keys; game_end reopens the letter set
    for (int c = 0; c < 8; c++)
      for (int n = 0; n < 8; n++) begin
        bus.correct = 3'(c); bus.incorrect = 3'(n);
        #1 chk("game_over_decode", bus.game_over, (c == 5) || (n == 6));
      end
    bus.incorrect = 3'd0; bus.correct = 3'd5;
    bus.game_rdy = 1'b1; bus.p2_key = 8'h44; bus.p2_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("game_over_no_ack", {bus.p1_ack, bus.p2_ack, bus.dup_reject}, 0);
    end
    bus.correct = 3'd0;
    pulse_game_end();
    chk("game_over_clear", bus.game_over, 0);
    do_key(8'h43, 1'b0, 1, 1'b0, 1, 1'b0, 1'b0);

    // random keys against the letter-set / turn model
    streak = 0;
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        pulse_game_end();
        streak = 0;
      end else if (r == 1) begin
        if ($urandom_range(0, 1) == 1) bus.correct = 3'd5; else bus.incorrect = 3'd6;
        bus.game_rdy = 1'b1;
        bus.p1_key = 8'h41; bus.p1_valid = 1'b1;
        bus.p2_key = 8'h42; bus.p2_valid = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("rnd_over_no_ack", {bus.p1_ack, bus.p2_ack, bus.guess}, 0);
        end
        bus.correct = 3'd0; bus.incorrect = 3'd0;
        drop_keys();
        @(negedge clk);
      end else begin
        if ($urandom_range(0, 3) == 0) k = 8'($urandom_range(0, 255));
        else k = 8'($urandom_range(65, 90));
        if (streak >= 6) begin
          r = $urandom_range(0, 25);
          k = 8'h00;
          for (int j = 0; j < 26; j++)
            if (k == 8'h00 && !mdl_used[(r + j) % 26]) k = 8'(65 + (r + j) % 26);
        end
        if (k == 8'h00 && streak >= 6) begin
          pulse_game_end();
          streak = 0;
        end else begin
          rej = !is_letter(k) || mdl_used[int'(k) - 65];
          bd  = $urandom_range(0, 2);
          mis = 1'($urandom_range(0, 1));
          npl = (!rej && bd < 2 && mis) ? ~mdl_player : mdl_player;
          do_key(k, rej, bd, mis, $urandom_range(1, 4), 1'($urandom_range(0, 1)), npl);
          streak = rej ? streak + 1 : 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
